// File: rtl/fifo_rr_controller_if.sv
// Handshake bundle for fifo_rr_controller: producer side, fifo side and output stream.
// The controller uses the master modport; the surrounding logic uses slave.
interface fifo_rr_controller_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_din;
    logic                     fifo_full;
    logic                     fifo_rd_en;
    logic [WIDTH-1:0]         fifo_dout;
    logic                     fifo_empty;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic [NUM_REQ*16-1:0]    grant_cnt;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_dout, fifo_empty, out_ready,
        output req_ready, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data, grant_cnt
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_dout, fifo_empty, out_ready,
        input  req_ready, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data, grant_cnt
    );
endinterface

// File: rtl/fifo_rr_controller.sv
// Round-robin write arbiter and read sequencer around a single registered-output fifo.
// Define FIFO_RR_STATS_EN to enable the per-producer saturating grant counters.
module fifo_rr_controller #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    fifo_rr_controller_if.master bus
);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_next;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]   din_sel;

    always_comb begin
        int j;
        j         = 0;
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_any && bus.req_valid[IDX_W'(j)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        if (rst || bus.fifo_full) grant_any = 1'b0;
        grant = '0;
        if (grant_any) grant[grant_idx] = 1'b1;
    end

    always_comb begin
        din_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) din_sel = bus.req_data[k*WIDTH +: WIDTH];
        end
    end

    assign rr_next        = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign bus.req_ready  = grant;
    assign bus.fifo_wr_en = grant_any;
    assign bus.fifo_din   = din_sel;

    // Read side: two-slot skid buffer absorbs the word still in flight from the fifo.
    logic [1:0]       buf_cnt;
    logic             head;
    logic             tail;
    logic             inflight;
    logic [WIDTH-1:0] buf_mem [2];
    logic             out_valid_c;
    logic             pop;
    logic             rd_en;
    logic [2:0]       occ;

    assign out_valid_c = !rst && (buf_cnt != 2'd0);
    assign pop         = out_valid_c && bus.out_ready;
    assign occ         = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_en       = !rst && !bus.fifo_empty && (occ < 3'd2);
    assign tail        = head ^ buf_cnt[0];

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_data   = buf_mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            buf_cnt  <= 2'd0;
            head     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            if (grant_any) rr_ptr <= rr_next;
            inflight <= rd_en;
            if (pop) head <= ~head;
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && inflight) buf_mem[tail] <= bus.fifo_dout;
    end

`ifdef FIFO_RR_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) cnt[k] <= 16'd0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (grant[k] && cnt[k] != 16'hFFFF) cnt[k] <= cnt[k] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign bus.grant_cnt[g*16 +: 16] = cnt[g];
    end
`else
    assign bus.grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_controller.sv
// Directed bench for fifo_rr_controller with a 32-deep registered-output fifo model.
module tb_fifo_rr_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef FIFO_RR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    fifo_rr_controller_if #(.WIDTH(8), .NUM_REQ(2)) bus ();

    fifo_rr_controller #(.WIDTH(8), .NUM_REQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Fifo model: reset together with the controller, dout registered on read.
    logic [7:0] fmem [32];
    int fcnt = 0;
    int frp  = 0;
    int fwp  = 0;
    assign bus.fifo_full  = (fcnt == 32);
    assign bus.fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            fcnt <= 0;
            frp  <= 0;
            fwp  <= 0;
        end else begin
            if (bus.fifo_wr_en && fcnt < 32) begin
                fmem[fwp] <= bus.fifo_din;
                fwp       <= (fwp + 1) % 32;
            end
            if (bus.fifo_rd_en && fcnt > 0) begin
                bus.fifo_dout <= fmem[frp];
                frp           <= (frp + 1) % 32;
            end
            fcnt <= fcnt + ((bus.fifo_wr_en && fcnt < 32) ? 1 : 0)
                         - ((bus.fifo_rd_en && fcnt > 0) ? 1 : 0);
        end
    end

    int rd_pulses = 0;
    always @(posedge clk) if (bus.fifo_rd_en) rd_pulses++;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int viol;
        bit full_seen;
        logic [7:0] exp6 [6];

        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_data  = 16'hB0A0;
        bus.out_ready = 1'b0;

        // reset: outputs gated while rst is high
        repeat (2) begin
            step();
            chk("rst_ready", bus.req_ready, 2'b00);
            chk("rst_wr", bus.fifo_wr_en, 1'b0);
            chk("rst_rd", bus.fifo_rd_en, 1'b0);
            chk("rst_ov", bus.out_valid, 1'b0);
        end

        // fairness: alternating grants, out_ready low so the buffer backs up
        rst  = 1'b0;
        base = rd_pulses;
        for (int k = 0; k < 6; k++) begin
            bus.req_data = {8'hB0 + 8'(k / 2), 8'hA0 + 8'((k + 1) / 2)};
            #1;
            chk("fair_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_wr", bus.fifo_wr_en, 1'b1);
            chk("fair_din", bus.fifo_din, (k % 2 == 0) ? 8'hA0 + 8'(k / 2) : 8'hB0 + 8'(k / 2));
            step();
        end
        bus.req_valid = 2'b00;
        #1;
        chk("idle_wr", bus.fifo_wr_en, 1'b0);
        chk("bp_ov", bus.out_valid, 1'b1);
        chk("bp_head", bus.out_data, 8'hA0);
        chk("gcnt_fair", bus.grant_cnt, STATS ? {16'd3, 16'd3} : 32'd0);

        // backpressure: only two reads issued while the buffer is full
        repeat (3) step();
        chk("bp_rd_pulses", rd_pulses - base, 2);
        chk("bp_ov_hold", bus.out_valid, 1'b1);

        bus.out_ready = 1'b1;
        exp6 = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("drain_ov", bus.out_valid, 1'b1);
            chk("drain_data", bus.out_data, exp6[k]);
            step();
        end
        #1;
        chk("drain_done", bus.out_valid, 1'b0);

        // latency/throughput: valid two cycles after empty drops, then back-to-back
        for (int c = 0; c < 8; c++) begin
            bus.req_valid     = (c < 4) ? 2'b01 : 2'b00;
            bus.req_data[7:0] = 8'h11 + 8'(c);
            #1;
            if (c < 4) chk("lat_ready", bus.req_ready, 2'b01);
            if (c == 0) begin
                chk("lat_empty0", bus.fifo_empty, 1'b1);
                chk("lat_rd0", bus.fifo_rd_en, 1'b0);
            end
            if (c == 1) begin
                chk("lat_empty1", bus.fifo_empty, 1'b0);
                chk("lat_rd1", bus.fifo_rd_en, 1'b1);
            end
            chk("lat_ov", bus.out_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("lat_data", bus.out_data, 8'h11 + 8'(c - 3));
            step();
        end

        // full: 32 in fifo plus 2 in buffer
        bus.out_ready      = 1'b0;
        bus.req_valid      = 2'b10;
        bus.req_data[15:8] = 8'h40;
        n         = 0;
        full_seen = 1'b0;
        for (int c = 0; c < 60 && !full_seen; c++) begin
            #1;
            if (bus.fifo_full) begin
                full_seen = 1'b1;
            end else begin
                if (bus.req_ready[1]) n++;
                step();
                bus.req_data[15:8] = 8'h40 + 8'(n);
            end
        end
        chk("full_flag", bus.fifo_full, 1'b1);
        chk("full_writes", n, 34);
        chk("gcnt_full", bus.grant_cnt, STATS ? {16'd37, 16'd7} : 32'd0);

        viol = 0;
        repeat (10) begin
            #1;
            if (bus.req_ready != 2'b00 || bus.fifo_wr_en) viol++;
            step();
        end
        chk("full_hold_viol", viol, 0);

        bus.out_ready = 1'b1;
        #1;
        chk("rel_ov", bus.out_valid, 1'b1);
        chk("rel_data", bus.out_data, 8'h40);
        chk("rel_rd", bus.fifo_rd_en, 1'b1);
        chk("rel_ready0", bus.req_ready, 2'b00);
        step();
        bus.out_ready = 1'b0;
        #1;
        chk("rel_grant", bus.req_ready, 2'b10);
        chk("rel_wr", bus.fifo_wr_en, 1'b1);
        chk("rel_din", bus.fifo_din, 8'h62);
        step();
        #1;
        chk("rel_full_again", bus.req_ready, 2'b00);
        chk("rel_head", bus.out_data, 8'h41);

        // mid-operation reset with buffered and queued words
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        chk("mrst_ov", bus.out_valid, 1'b0);
        chk("mrst_ready", bus.req_ready, 2'b00);
        chk("mrst_wr", bus.fifo_wr_en, 1'b0);
        chk("mrst_rd", bus.fifo_rd_en, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("post_ov", bus.out_valid, 1'b0);
        chk("post_empty", bus.fifo_empty, 1'b1);
        chk("post_ptr", bus.req_ready, 2'b01);
        chk("post_gcnt", bus.grant_cnt, 32'd0);
        step();
        #1;
        chk("post_ov2", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
